// File: rtl/rf_pkg.sv
// Shared defaults and FSM state encoding for the register-file read streamer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DEPTH  = 1 << RF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rf_skid_buf.sv
// Two-entry FIFO holding {last, addr, data} words between the register file and the consumer.
// Latency: a push is visible at the head one cycle later; the head is combinational from storage.
// Backpressure: the caller guarantees space; a push into a full buffer without a pop is dropped.
module rf_skid_buf #(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic [1:0]   cnt
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop   = pop && (cnt != 2'd0);
  assign do_push  = push && ((cnt != 2'd2) || do_pop);
  assign head_dat = mem[rd_ptr];

  // Storage, pointers and occupancy; reset clears contents so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/regfile_read_streamer.sv
// Streams COUNT consecutive register-file words (wrapping addresses) out on a valid/ready port.
// Latency: start sampled at edge E0 -> rd_en in the next cycle -> out_valid after E2; 1 word/cycle when ready.
// Backpressure: a read is issued only when in-flight + buffered words (less one being popped) is below 2.
module regfile_read_streamer
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = RF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              done
);

  localparam int CW = ADDR_W + 1;
  localparam int EW = 1 + ADDR_W + DATA_W;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0]     remaining;
  logic [CW-1:0]     count_clamped;
  logic              infl_vld;
  logic              infl_last;
  logic [ADDR_W-1:0] infl_addr;
  logic [1:0]        buf_cnt;
  logic [EW-1:0]     head;
  logic              pop;
  logic [2:0]        used;
  logic              last_issue;
  logic              cmd_accept;

  // Counts above DEPTH would re-read registers; clamp so each is read at most once.
  assign count_clamped = (count > CW'(DEPTH)) ? CW'(DEPTH) : count;

  // Occupancy seen by the credit check: registered counts, minus a word leaving this cycle.
  assign used       = 3'(infl_vld) + 3'(buf_cnt) - 3'(pop);
  assign last_issue = rd_en && (remaining == CW'(1));
  assign cmd_accept = (state == IDLE) && start && (count != '0);

  assign rd_addr   = addr;
  assign out_valid = (buf_cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_last  = head[EW-1];
  assign out_addr  = head[DATA_W +: ADDR_W];
  assign out_data  = head[DATA_W-1:0];

  // State register plus address/remaining counters and the one-deep in-flight read tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      infl_vld  <= 1'b0;
      infl_last <= 1'b0;
      infl_addr <= '0;
    end else begin
      state    <= state_nxt;
      infl_vld <= rd_en;
      if (rd_en) begin
        infl_addr <= addr;
        infl_last <= last_issue;
      end
      if (cmd_accept) begin
        addr      <= start_addr;
        remaining <= count_clamped;
      end else if (rd_en) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - CW'(1);
      end
    end
  end

  // Next-state and FSM outputs; the read request is gated by the credit check.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (count == '0) ? DONE : READ;
        end
      end
      READ: begin
        rd_en = (used < 3'd2);
        if (rd_en && (remaining == CW'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  rf_skid_buf #(
    .W (EW)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (infl_vld),
    .push_dat ({infl_last, infl_addr, rd_data}),
    .pop      (pop),
    .head_dat (head),
    .cnt      (buf_cnt)
  );

endmodule

// File: tb/tb_regfile_read_streamer.sv
// Scoreboard bench for regfile_read_streamer with a modelled synchronous register file.
// Latency: expectations are queued at command issue and consumed by an independent monitor.
// Backpressure: out_ready is either held high or driven in a 1,0,0 repeating pattern.
module tb_regfile_read_streamer;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREG = 32;

  typedef struct packed {
    logic          last;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   count;
  logic          busy;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          done;

  logic [DW-1:0] rf [NREG];
  word_t         exp_q [$];
  word_t         cur;
  word_t         prev_w;
  word_t         e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int words_seen = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  int done_cyc = -1;
  int issued = 0;
  int accepted = 0;
  int pcyc = 0;
  int outst;
  bit no_rd = 1'b0;
  bit ready_pat = 1'b0;
  bit prev_stall = 1'b0;

  regfile_read_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .busy       (busy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read register file model.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= rf[rd_addr];
  end

  // Consumer ready: held high, or the 1,0,0 stall pattern.
  always @(posedge clk) begin
    #1;
    out_ready = ready_pat ? (pcyc % 3 == 0) : 1'b1;
    pcyc++;
  end

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: scoreboard pops, hold-while-stalled, credit bound, no-read windows, done timing.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
      issued     = 0;
      accepted   = 0;
    end else begin
      cur.last = out_last;
      cur.addr = out_addr;
      cur.data = out_data;
      if (prev_stall) begin
        check(out_valid == 1'b1, "stall_valid_held", out_valid, 1);
        check(cur == prev_w, "stall_word_held", cur.data, prev_w.data);
      end
      if (no_rd) check(rd_en == 1'b0, "no_rd_en_count0", rd_en, 0);
      if (rd_en) begin
        outst = issued - accepted - ((out_valid && out_ready) ? 1 : 0);
        check(outst < 2, "credit_bound", outst, 1);
        issued++;
      end
      if (out_valid && out_ready) begin
        accepted++;
        words_seen++;
        if (first_cyc < 0) first_cyc = cyc;
        if (out_last) last_cyc = cyc;
        check(exp_q.size() != 0, "unexpected_word", out_addr, -1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check(out_data == e.data, "out_data", out_data, e.data);
          check(out_addr == e.addr, "out_addr", out_addr, e.addr);
          check(out_last == e.last, "out_last", out_last, e.last);
        end
      end
      if (done) done_cyc = cyc;
      prev_stall = out_valid && !out_ready;
      prev_w     = cur;
    end
  end

  task automatic issue(input int sa, input int cnt, input bit expect_it);
    int n;
    word_t w;
    @(posedge clk); #2;
    start      = 1'b1;
    start_addr = AW'(sa);
    count      = (AW+1)'(cnt);
    if (expect_it) begin
      n = (cnt > NREG) ? NREG : cnt;
      for (int i = 0; i < n; i++) begin
        w.addr = AW'((sa + i) % NREG);
        w.data = rf[w.addr];
        w.last = (i == n - 1);
        exp_q.push_back(w);
      end
    end
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 400; k++) begin
      if (!busy) break;
      @(posedge clk); #2;
    end
    check(busy == 1'b0, {name, "_idle"}, busy, 0);
    check(exp_q.size() == 0, {name, "_all_words"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws;
    int target;
    for (int i = 0; i < NREG; i++) rf[i] = DW'(10 * i);
    rst = 1'b1; start = 1'b0; start_addr = '0; count = '0;
    #1;
    check(busy == 0, "rst_busy", busy, 0);
    check(rd_en == 0, "rst_rd_en", rd_en, 0);
    check(out_valid == 0, "rst_out_valid", out_valid, 0);
    check(done == 0, "rst_done", done, 0);
    check(out_data == 0 && out_addr == 0 && out_last == 0 && rd_addr == 0, "rst_data_addr", out_data, 0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;

    // 1: addr 0, four words, full-rate consumer.
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
    issue(0, 4, 1);
    wait_idle("t1");
    check(last_cyc - first_cyc == 3, "t1_back_to_back", last_cyc - first_cyc, 3);
    check(done_cyc == last_cyc + 1, "t1_done_after_last", done_cyc - last_cyc, 1);

    // 2: wrap 30,31,0,1.
    issue(30, 4, 1);
    wait_idle("t2");

    // 3: all 32 words under the 1,0,0 stall pattern.
    ready_pat = 1'b1;
    issue(0, 32, 1);
    wait_idle("t3");
    ready_pat = 1'b0;

    // 4a: count 0 -> no reads, done in the cycle after start is sampled.
    no_rd = 1'b1;
    @(posedge clk); #2;
    start = 1'b1; start_addr = 5'd9; count = '0;
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk); #1;
    check(done == 1'b1, "t4_done_pulse", done, 1);
    check(busy == 1'b1, "t4_busy_in_done", busy, 1);
    @(negedge clk); #1;
    check(done == 1'b0, "t4_done_one_cycle", done, 0);
    check(busy == 1'b0, "t4_idle_after", busy, 0);
    no_rd = 1'b0;

    // 4b: count 40 clamps to 32 words.
    ws = words_seen;
    issue(7, 40, 1);
    wait_idle("t4b");
    check(words_seen - ws == 32, "t4b_word_count", words_seen - ws, 32);

    // 5: a second start while busy is ignored.
    ws = words_seen;
    issue(3, 5, 1);
    @(posedge clk); #2;
    start = 1'b1; start_addr = 5'd20; count = 6'd2;
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle("t5");
    repeat (6) @(posedge clk);
    #2;
    check(words_seen - ws == 5, "t5_ignored_start", words_seen - ws, 5);

    // 6: reset after the third word of an 8-word command, then a clean restart.
    issue(5, 8, 1);
    target = words_seen + 3;
    for (int k = 0; k < 100; k++) begin
      if (words_seen >= target) break;
      @(posedge clk); #2;
    end
    check(words_seen >= target, "t6_reach_third", words_seen, target);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check(busy == 0 && done == 0, "t6_rst_busy_done", busy, 0);
    check(out_valid == 0 && rd_en == 0, "t6_rst_valid_rd", out_valid, 0);
    check(out_data == 0 && out_addr == 0 && out_last == 0, "t6_rst_out_zero", out_data, 0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    first_cyc = -1;
    ws = words_seen;
    issue(12, 3, 1);
    wait_idle("t6");
    check(words_seen - ws == 3, "t6_restart_count", words_seen - ws, 3);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
